// File: rtl/rob_alloc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_alloc_ctrl_pkg
// Description : Shared types and helpers for the ROB allocate/commit sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_alloc_ctrl_pkg;

    // Default log2 of the ROB depth.
    localparam int C_ROB_WIDTH = 6;

    // Sequencer states. The width is explicit so the encoding is stable.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2
    } rob_ctrl_state_e;

    // Dispatch-side bundle at the default ROB width.
    typedef struct packed {
        logic [1:0][C_ROB_WIDTH-1:0] id;
        logic [1:0]                  fire;
    } rob_alloc_pkg_t;

    // Commit-side bundle at the default ROB width.
    typedef struct packed {
        logic [1:0][C_ROB_WIDTH-1:0] ptr;
        logic [1:0]                  valid;
    } rob_commit_sel_t;

    // Number of set bits in a 2-bit slot mask.
    function automatic logic [1:0] popcnt2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_alloc_ctrl_ptr_cnt.sv
`default_nettype none
// ============================================================================
// Module      : rob_alloc_ctrl_ptr_cnt
// Description : Head (allocate), tail (retire) and occupancy registers of the
//               ROB, with the mod-depth pointer adders.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_alloc_ctrl_ptr_cnt #(
    parameter int ROB_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic [1:0]           nalloc_i,
    input  logic [1:0]           ncommit_i,
    output logic [ROB_WIDTH-1:0] head_o,
    output logic [ROB_WIDTH-1:0] tail_o,
    output logic [ROB_WIDTH:0]   cnt_o
);

    logic [ROB_WIDTH-1:0] r_head;
    logic [ROB_WIDTH-1:0] r_tail;
    logic [ROB_WIDTH:0]   r_cnt;

    // Pointers wrap naturally at the power-of-two depth; the parent only grants
    // allocations that fit, so the count never exceeds the depth.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            r_head <= r_head + ROB_WIDTH'(nalloc_i);
            r_tail <= r_tail + ROB_WIDTH'(ncommit_i);
            r_cnt  <= r_cnt + (ROB_WIDTH+1)'(nalloc_i) - (ROB_WIDTH+1)'(ncommit_i);
        end
    end

    assign head_o = r_head;
    assign tail_o = r_tail;
    assign cnt_o  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/rob_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rob_alloc_ctrl
// Description : ROB sequencer. Grants 2-wide dispatch its ROB ids, presents
//               in-order 2-wide commit candidates and runs the
//               RUN/FLUSH/RECOVER sequence after a commit-stage redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_alloc_ctrl
    import rob_alloc_ctrl_pkg::*;
#(
    parameter int ROB_WIDTH      = C_ROB_WIDTH,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                alloc_req_i,
    output logic                      alloc_ready_o,
    output logic [1:0][ROB_WIDTH-1:0] alloc_id_o,
    output logic [1:0]                alloc_fire_o,
    output logic [1:0][ROB_WIDTH-1:0] commit_ptr_o,
    input  logic [1:0]                complete_i,
    output logic [1:0]                commit_valid_o,
    input  logic [1:0]                commit_ack_i,
    input  logic                      redirect_i,
    output logic                      flush_o,
    output logic [ROB_WIDTH:0]        rob_cnt_o,
    output logic                      rob_full_o,
    output logic                      rob_empty_o
);

    localparam logic [ROB_WIDTH:0] C_DEPTH   = {1'b1, {ROB_WIDTH{1'b0}}};
    localparam logic [3:0]         C_RECOVER = 4'(RECOVER_CYCLES);

    rob_ctrl_state_e      r_state;
    logic [3:0]           r_recover_cnt;

    logic [ROB_WIDTH-1:0] w_head;
    logic [ROB_WIDTH-1:0] w_tail;
    logic [ROB_WIDTH:0]   w_cnt;
    logic [ROB_WIDTH:0]   w_free;
    logic                 w_run;
    logic                 w_ready;
    logic                 w_cv0;
    logic                 w_cv1;
    logic [1:0]           w_nreq;
    logic [1:0]           w_fire;
    logic [1:0]           w_commit_eff;
    logic [1:0]           w_nalloc;
    logic [1:0]           w_ncommit;
    logic                 w_clear;

    // Dispatch grant, commit candidates and pointer-advance amounts.
    always_comb begin
        w_run   = (r_state == ST_RUN);
        w_nreq  = popcnt2(alloc_req_i);
        // Free space uses the registered count only; same-cycle retirements
        // do not create room, and requests are granted all-or-nothing.
        w_free  = C_DEPTH - w_cnt;
        w_ready = w_run && (w_free >= {{(ROB_WIDTH-1){1'b0}}, w_nreq});
        w_fire  = alloc_req_i & {2{w_ready}};

        w_cv0 = w_run & complete_i[0] & (w_cnt != '0);
        w_cv1 = w_run & complete_i[1] & (w_cnt > (ROB_WIDTH+1)'(1)) & w_cv0;
        // Retirement is strictly in order: slot 1 only retires behind slot 0.
        w_commit_eff = {commit_ack_i[1] & commit_ack_i[0] & w_cv1,
                        commit_ack_i[0] & w_cv0};

        w_nalloc  = popcnt2(w_fire);
        w_ncommit = popcnt2(w_commit_eff);
        w_clear   = w_run & redirect_i;
    end

    assign alloc_ready_o   = w_ready;
    assign alloc_fire_o    = w_fire;
    // A lone slot-1 request takes head itself.
    assign alloc_id_o[0]   = w_head;
    assign alloc_id_o[1]   = w_head + ROB_WIDTH'(alloc_req_i[0]);
    assign commit_ptr_o[0] = w_tail;
    assign commit_ptr_o[1] = w_tail + ROB_WIDTH'(1);
    assign commit_valid_o  = {w_cv1, w_cv0};
    assign flush_o         = (r_state == ST_FLUSH);
    assign rob_cnt_o       = w_cnt;
    assign rob_full_o      = (w_cnt == C_DEPTH);
    assign rob_empty_o     = (w_cnt == '0);

    rob_alloc_ctrl_ptr_cnt #(
        .ROB_WIDTH (ROB_WIDTH)
    ) u_ptr_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (w_clear),
        .nalloc_i  (w_nalloc),
        .ncommit_i (w_ncommit),
        .head_o    (w_head),
        .tail_o    (w_tail),
        .cnt_o     (w_cnt)
    );

    // Redirect sequencer: one flush cycle, then hold dispatch for the recovery window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_recover_cnt <= 4'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (redirect_i) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (C_RECOVER == 4'd0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_state       <= ST_RECOVER;
                        r_recover_cnt <= C_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    r_recover_cnt <= r_recover_cnt - 4'd1;
                    if (r_recover_cnt <= 4'd1) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_alloc_ctrl
// Description : Scoreboard bench for rob_alloc_ctrl (ROB_WIDTH=6,
//               RECOVER_CYCLES=2) driven by directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_alloc_ctrl;

    localparam int W = 6;

    localparam int K_READY  = 0;
    localparam int K_CNT    = 1;
    localparam int K_FULL   = 2;
    localparam int K_EMPTY  = 3;
    localparam int K_CVALID = 4;
    localparam int K_FLUSH  = 5;
    localparam int K_TAIL   = 6;
    localparam int K_HEAD   = 7;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    typedef struct {
        logic [1:0]   fire;
        logic [W-1:0] id0;
        logic [W-1:0] id1;
    } fire_t;

    exp_t  q[$];
    fire_t fq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        alloc_req;
    logic              alloc_ready;
    logic [1:0][W-1:0] alloc_id;
    logic [1:0]        alloc_fire;
    logic [1:0][W-1:0] commit_ptr;
    logic [1:0]        complete;
    logic [1:0]        commit_valid;
    logic [1:0]        commit_ack;
    logic              redirect;
    logic              flush;
    logic [W:0]        rob_cnt;
    logic              rob_full;
    logic              rob_empty;

    rob_alloc_ctrl #(
        .ROB_WIDTH      (W),
        .RECOVER_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_req_i    (alloc_req),
        .alloc_ready_o  (alloc_ready),
        .alloc_id_o     (alloc_id),
        .alloc_fire_o   (alloc_fire),
        .commit_ptr_o   (commit_ptr),
        .complete_i     (complete),
        .commit_valid_o (commit_valid),
        .commit_ack_i   (commit_ack),
        .redirect_i     (redirect),
        .flush_o        (flush),
        .rob_cnt_o      (rob_cnt),
        .rob_full_o     (rob_full),
        .rob_empty_o    (rob_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_READY:  return 32'(alloc_ready);
            K_CNT:    return 32'(rob_cnt);
            K_FULL:   return 32'(rob_full);
            K_EMPTY:  return 32'(rob_empty);
            K_CVALID: return 32'(commit_valid);
            K_FLUSH:  return 32'(flush);
            K_TAIL:   return 32'(commit_ptr[0]);
            K_HEAD:   return 32'(alloc_id[0]);
            default:  return 32'hdead_beef;
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle, and every fire event.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t        e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.kind);
            checks++;
            if (e.cyc != cyc || a !== e.val) begin
                errors++;
                $display("FAIL %s cyc=%0d actual=%0d required=%0d", e.name, e.cyc, a, e.val);
            end
        end
        if (alloc_fire != 2'b00) begin
            checks++;
            if (fq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_fire cyc=%0d actual=%b required=none", cyc, alloc_fire);
            end else begin
                fire_t f;
                f = fq.pop_front();
                if (alloc_fire !== f.fire || alloc_id[0] !== f.id0 || alloc_id[1] !== f.id1) begin
                    errors++;
                    $display("FAIL fire_ids cyc=%0d actual=%b/{%0d,%0d} required=%b/{%0d,%0d}",
                             cyc, alloc_fire, alloc_id[1], alloc_id[0], f.fire, f.id1, f.id0);
                end
            end
        end
    end

    task automatic drive(input logic [1:0] req, input logic [1:0] cmp,
                         input logic [1:0] ack, input logic red);
        alloc_req  = req;
        complete   = cmp;
        commit_ack = ack;
        redirect   = red;
    endtask

    task automatic expect_now(input int kind, input int val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = 32'(val);
        e.name = name;
        q.push_back(e);
    endtask

    task automatic expect_fire(input logic [1:0] fire, input int head);
        fire_t f;
        f.fire = fire;
        f.id0  = W'(head);
        f.id1  = W'(head + int'(fire[0]));
        fq.push_back(f);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        step();
        do_reset();

        // Reset state; complete/ack asserted to show nothing commits when empty.
        drive(2'b00, 2'b11, 2'b11, 1'b0);
        expect_now(K_READY, 1, "rst_ready");
        expect_now(K_CNT, 0, "rst_cnt");
        expect_now(K_EMPTY, 1, "rst_empty");
        expect_now(K_FULL, 0, "rst_full");
        expect_now(K_FLUSH, 0, "rst_flush");
        expect_now(K_CVALID, 0, "rst_cvalid");
        expect_now(K_HEAD, 0, "rst_head");
        expect_now(K_TAIL, 0, "rst_tail");
        step();

        // Fill with 2-wide dispatch: ids 0,1 .. 62,63.
        for (int i = 0; i < 32; i++) begin
            drive(2'b11, 2'b00, 2'b00, 1'b0);
            expect_now(K_READY, 1, "fill_ready");
            expect_now(K_CNT, 2 * i, "fill_cnt");
            expect_fire(2'b11, 2 * i);
            step();
        end
        drive(2'b11, 2'b00, 2'b00, 1'b0);
        expect_now(K_CNT, 64, "full_cnt");
        expect_now(K_FULL, 1, "full_flag");
        expect_now(K_READY, 0, "full_ready");
        step();

        // Full: commit two while dispatch asks for two.
        drive(2'b11, 2'b11, 2'b11, 1'b0);
        expect_now(K_READY, 0, "full_commit_ready");
        expect_now(K_CVALID, 3, "full_commit_cvalid");
        expect_now(K_TAIL, 0, "full_commit_tail");
        expect_now(K_HEAD, 0, "full_head_wrapped");
        step();
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        expect_now(K_CNT, 62, "after_commit_cnt");
        expect_now(K_TAIL, 2, "after_commit_tail");
        step();

        // 62 -> 63 with one slot, then a 2-wide request must be refused.
        drive(2'b01, 2'b00, 2'b00, 1'b0);
        expect_now(K_READY, 1, "one_free_ready");
        expect_fire(2'b01, 0);
        step();
        drive(2'b11, 2'b00, 2'b00, 1'b0);
        expect_now(K_CNT, 63, "cnt63");
        expect_now(K_READY, 0, "cnt63_pair_ready");
        step();
        drive(2'b01, 2'b00, 2'b00, 1'b0);
        expect_now(K_READY, 1, "cnt63_single_ready");
        expect_fire(2'b01, 1);
        step();
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        expect_now(K_CNT, 64, "cnt64_again");
        expect_now(K_FULL, 1, "full_again");
        expect_now(K_HEAD, 2, "head2");
        step();

        // Head wrap: bring head to 63.
        do_reset();
        for (int i = 0; i < 31; i++) begin
            drive(2'b11, 2'b00, 2'b00, 1'b0);
            expect_fire(2'b11, 2 * i);
            step();
        end
        drive(2'b01, 2'b00, 2'b00, 1'b0);
        expect_fire(2'b01, 62);
        step();
        drive(2'b00, 2'b11, 2'b11, 1'b0);
        expect_now(K_CNT, 63, "wrap_cnt63");
        expect_now(K_HEAD, 63, "wrap_head63");
        expect_now(K_CVALID, 3, "wrap_cvalid");
        step();
        drive(2'b11, 2'b00, 2'b00, 1'b0);
        expect_now(K_CNT, 61, "wrap_cnt61");
        expect_now(K_READY, 1, "wrap_ready");
        expect_fire(2'b11, 63);
        step();
        // Slot 1 complete alone is not a candidate; its ack is ignored.
        drive(2'b00, 2'b10, 2'b10, 1'b0);
        expect_now(K_HEAD, 1, "wrap_head1");
        expect_now(K_CNT, 63, "wrap_cnt63b");
        expect_now(K_CVALID, 0, "slot1_only_cvalid");
        expect_now(K_TAIL, 2, "slot1_only_tail");
        step();
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        expect_now(K_TAIL, 2, "slot1_ack_tail");
        expect_now(K_CNT, 63, "slot1_ack_cnt");
        step();

        // Redirect at cnt=10 with slot 0 retiring.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, 2'b00, 2'b00, 1'b0);
            expect_fire(2'b11, 2 * i);
            step();
        end
        drive(2'b00, 2'b01, 2'b01, 1'b1);
        expect_now(K_CNT, 10, "redir_cnt10");
        expect_now(K_CVALID, 1, "redir_cvalid");
        expect_now(K_READY, 1, "redir_ready");
        step();
        drive(2'b11, 2'b11, 2'b11, 1'b0);
        expect_now(K_FLUSH, 1, "flush_pulse");
        expect_now(K_CNT, 0, "flush_cnt");
        expect_now(K_READY, 0, "flush_ready");
        expect_now(K_CVALID, 0, "flush_cvalid");
        expect_now(K_HEAD, 0, "flush_head");
        step();
        drive(2'b11, 2'b11, 2'b11, 1'b1);
        expect_now(K_FLUSH, 0, "rec1_flush");
        expect_now(K_READY, 0, "rec1_ready");
        expect_now(K_CVALID, 0, "rec1_cvalid");
        step();
        drive(2'b11, 2'b11, 2'b11, 1'b0);
        expect_now(K_READY, 0, "rec2_ready");
        expect_now(K_FLUSH, 0, "rec2_flush");
        step();
        drive(2'b11, 2'b00, 2'b00, 1'b0);
        expect_now(K_READY, 1, "post_recover_ready");
        expect_now(K_CNT, 0, "post_recover_cnt");
        expect_fire(2'b11, 0);
        step();

        // Reset in the middle of RECOVER.
        drive(2'b00, 2'b00, 2'b00, 1'b1);
        expect_now(K_CNT, 2, "redir2_cnt");
        step();
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        expect_now(K_FLUSH, 1, "flush2_pulse");
        step();
        rst = 1'b1;
        expect_now(K_READY, 0, "rec_before_rst_ready");
        expect_now(K_FLUSH, 0, "rec_before_rst_flush");
        step();
        rst = 1'b0;
        expect_now(K_READY, 1, "rst_mid_rec_ready");
        expect_now(K_FLUSH, 0, "rst_mid_rec_flush");
        expect_now(K_CNT, 0, "rst_mid_rec_cnt");
        expect_now(K_EMPTY, 1, "rst_mid_rec_empty");
        step();
        step();

        @(negedge clk);
        #1;
        checks++;
        if (fq.size() != 0) begin
            errors++;
            $display("FAIL fires_outstanding actual=%0d required=0", fq.size());
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL checks_outstanding actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
